// File: rtl/uart_tx_mmio_if.sv
// CPU data-bus bundle for the memory-mapped UART transmitter.
// The cpu drives address, store data and strobes; the slave returns registered read data.
interface uart_tx_mmio_if;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic        re;
  logic        we;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output re, output we, input rdata);
  modport slave  (input addr, input wdata, input re, input we, output rdata);
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter.
// DATA (BASE_ADDR) pushes a byte into a small circular FIFO; STATUS (BASE_ADDR+1)
// reports {count, overrun, empty, full, busy}. A baud-timed FSM drains the FIFO onto tx,
// chaining frames back-to-back while bytes are queued.
module uart_tx_mmio #(
  parameter logic [29:0] BASE_ADDR  = 30'h3FFFFFF0,
  parameter int          CLK_DIV    = 104,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_mmio_if.slave  bus,
  output logic           tx,
  output logic           busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Address decode and bus strobes
  logic sel;
  logic is_status;
  logic wr_req;
  logic rd_status;

  assign sel       = (bus.addr[29:1] == BASE_ADDR[29:1]);
  assign is_status = bus.addr[0];
  assign wr_req    = bus.we & sel & ~is_status;
  assign rd_status = bus.re & sel & is_status;

  // FIFO storage and bookkeeping
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             overrun_reg;
  logic             empty;
  logic             full;
  logic [7:0]       head;

  // Transmit FSM state
  logic [1:0]  state_reg;
  logic [15:0] baud_cnt_reg;
  logic [2:0]  bit_idx_reg;
  logic [7:0]  shift_reg;
  logic        tx_reg;
  logic        baud_last;

  logic push;
  logic pop;
  logic overrun_set;

  logic unused_wdata;
  assign unused_wdata = ^bus.wdata[31:8];

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CNT_W'(FIFO_DEPTH));
  assign head      = fifo_mem[rd_ptr_reg];
  assign baud_last = (baud_cnt_reg == 16'(CLK_DIV - 1));

  // The FSM takes a byte when idle, or at the end of a stop bit so frames chain without a gap.
  assign pop = ~empty & ((state_reg == ST_IDLE) | ((state_reg == ST_STOP) & baud_last));
  // A store into a full FIFO still lands if the FSM frees a slot on the same edge.
  assign push        = wr_req & (~full | pop);
  assign overrun_set = wr_req & full & ~pop;

  assign busy = (state_reg != ST_IDLE) | ~empty;
  assign tx   = tx_reg;

  // FIFO storage write; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= bus.wdata[7:0];
    end
  end

  // FIFO pointers and occupancy count, wrapping naturally at the power-of-two depth
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Sticky overrun flag: cleared by a STATUS read unless a new drop happens on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_reg <= 1'b0;
    end else begin
      overrun_reg <= overrun_set | (overrun_reg & ~rd_status);
    end
  end

  // Registered read data, zero when not selected so it can be OR-combined with other slaves
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rdata <= '0;
    end else if (rd_status) begin
      bus.rdata <= {24'b0, 4'(count_reg), overrun_reg, empty, full, busy};
    end else begin
      bus.rdata <= '0;
    end
  end

  // Baud-timed frame generator; tx is registered alongside the state it belongs to
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!empty) begin
            state_reg    <= ST_START;
            baud_cnt_reg <= '0;
            shift_reg    <= head;
            tx_reg       <= 1'b0;
          end
        end
        ST_START: begin
          if (baud_last) begin
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            state_reg    <= ST_DATA;
            tx_reg       <= shift_reg[0];
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 16'd1;
          end
        end
        ST_DATA: begin
          if (baud_last) begin
            baud_cnt_reg <= '0;
            if (bit_idx_reg == 3'd7) begin
              state_reg <= ST_STOP;
              tx_reg    <= 1'b1;
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
              shift_reg   <= {1'b0, shift_reg[7:1]};
              tx_reg      <= shift_reg[1];
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 16'd1;
          end
        end
        ST_STOP: begin
          if (baud_last) begin
            baud_cnt_reg <= '0;
            if (!empty) begin
              state_reg <= ST_START;
              shift_reg <= head;
              tx_reg    <= 1'b0;
            end else begin
              state_reg <= ST_IDLE;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 16'd1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          tx_reg    <= 1'b1;
        end
      endcase
    end
  end

endmodule
